// File: rtl/cpu_rf_pkg.sv
// Shared types and defaults for the register-file port arbiter.
package cpu_rf_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int SEL_W_DEF  = 4;
  localparam int R0_SEL     = 0;

  typedef enum logic [2:0] {
    IDLE,
    WR_WAIT,
    RD_WAIT,
    RD_CAP,
    RSP
  } rf_port_state_e;

endpackage

// File: rtl/cpu_rf_port_ctrl_if.sv
// Host request/response channel into the register-file port arbiter.
interface cpu_rf_port_ctrl_if #(
  parameter int DATA_W = 32,
  parameter int SEL_W  = 4
);
  logic              host_req_valid;
  logic              host_req_ready;
  logic              host_req_we;
  logic [SEL_W-1:0]  host_req_sel;
  logic [DATA_W-1:0] host_req_data;
  logic              host_rsp_valid;
  logic              host_rsp_ready;
  logic [DATA_W-1:0] host_rsp_data;
  logic              host_rsp_err;

  modport master (
    output host_req_valid, host_req_we, host_req_sel, host_req_data, host_rsp_ready,
    input  host_req_ready, host_rsp_valid, host_rsp_data, host_rsp_err
  );

  modport slave (
    input  host_req_valid, host_req_we, host_req_sel, host_req_data, host_rsp_ready,
    output host_req_ready, host_rsp_valid, host_rsp_data, host_rsp_err
  );
endinterface

// File: rtl/cpu_rf_starve_ctr.sv
// Counts cycles the host is held off by the CPU; fire_o grants the host once MAX_WAIT is reached.
module cpu_rf_starve_ctr #(
  parameter int MAX_WAIT = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic waiting_i,
  input  logic blocked_i,
  output logic fire_o
);
  localparam int CW = $clog2(MAX_WAIT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign fire_o = waiting_i && (cnt_q == CW'(MAX_WAIT));

  // Any cycle that is not a blocked wait (including a grant) clears the count.
  always_comb begin
    cnt_d = '0;
    if (waiting_i && blocked_i && !fire_o && (cnt_q != '1))
      cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
endmodule

// File: rtl/cpu_rf_port_ctrl.sv
// Shares the RF write port and read port 2 between CPU (priority) and a host requester.
// Optional starvation guard enabled by defining CPU_RF_STARVE_GUARD_EN.
module cpu_rf_port_ctrl
  import cpu_rf_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int SEL_W    = SEL_W_DEF,
  parameter int MAX_WAIT = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_wr_en,
  input  logic [SEL_W-1:0]  cpu_wr_sel,
  input  logic [DATA_W-1:0] cpu_wr_data,
  input  logic [SEL_W-1:0]  cpu_sel2,
  input  logic              cpu_rd2_active,
  output logic              cpu_stall,
  cpu_rf_port_ctrl_if.slave host,
  output logic              rf_wrt_en,
  output logic [SEL_W-1:0]  rf_wrt_sel,
  output logic [DATA_W-1:0] rf_wrt_data,
  output logic [SEL_W-1:0]  rf_sel2,
  input  logic [DATA_W-1:0] rf_reg2
);
  rf_port_state_e    state_q;
  logic [SEL_W-1:0]  req_sel_q;
  logic [DATA_W-1:0] req_data_q;
  logic [DATA_W-1:0] rsp_data_q;
  logic              rsp_err_q;
  logic              fire;
  logic              wr_grant, rd_grant, host_wr_ok;

`ifdef CPU_RF_STARVE_GUARD_EN
  logic waiting, blocked;
  assign waiting = (state_q == WR_WAIT) || (state_q == RD_WAIT);
  assign blocked = ((state_q == WR_WAIT) && cpu_wr_en) ||
                   ((state_q == RD_WAIT) && cpu_rd2_active);

  cpu_rf_starve_ctr #(.MAX_WAIT(MAX_WAIT)) u_starve (
    .clk       (clk),
    .rst       (rst),
    .waiting_i (waiting),
    .blocked_i (blocked),
    .fire_o    (fire)
  );
`else
  assign fire = 1'b0;
`endif

  assign cpu_stall  = fire;
  assign wr_grant   = (state_q == WR_WAIT) && (!cpu_wr_en || fire);
  assign rd_grant   = (state_q == RD_WAIT) && (!cpu_rd2_active || fire);
  // Zero written to R0 is accepted as a no-op; only nonzero data is rejected.
  assign host_wr_ok = (req_sel_q != SEL_W'(R0_SEL)) || (req_data_q == '0);

  assign host.host_req_ready = (state_q == IDLE);
  assign host.host_rsp_valid = (state_q == RSP);
  assign host.host_rsp_data  = rsp_data_q;
  assign host.host_rsp_err   = rsp_err_q;

  always_comb begin
    rf_wrt_en   = cpu_wr_en && !fire;
    rf_wrt_sel  = cpu_wr_sel;
    rf_wrt_data = cpu_wr_data;
    rf_sel2     = cpu_sel2;
    if (wr_grant) begin
      rf_wrt_en   = host_wr_ok;
      rf_wrt_sel  = req_sel_q;
      rf_wrt_data = req_data_q;
    end
    if (rd_grant)
      rf_sel2 = req_sel_q;
  end

  always_ff @(posedge clk) begin
    if (host.host_req_valid && (state_q == IDLE)) begin
      req_sel_q  <= host.host_req_sel;
      req_data_q <= host.host_req_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE:
          if (host.host_req_valid)
            state_q <= host.host_req_we ? WR_WAIT : RD_WAIT;
        WR_WAIT:
          if (wr_grant) begin
            rsp_data_q <= '0;
            rsp_err_q  <= !host_wr_ok;
            state_q    <= RSP;
          end
        RD_WAIT:
          if (rd_grant) state_q <= RD_CAP;
        RD_CAP: begin
          rsp_data_q <= rf_reg2;
          rsp_err_q  <= 1'b0;
          state_q    <= RSP;
        end
        RSP:
          if (host.host_rsp_ready) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cpu_rf_port_ctrl.sv
// Scoreboarded bench for cpu_rf_port_ctrl with a behavioural register file (registered read, bypass).
module tb_cpu_rf_port_ctrl;
  localparam int DW = 32;
  localparam int SW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          cpu_wr_en, cpu_rd2_active, cpu_stall;
  logic [SW-1:0] cpu_wr_sel, cpu_sel2;
  logic [DW-1:0] cpu_wr_data;
  logic          rf_wrt_en;
  logic [SW-1:0] rf_wrt_sel, rf_sel2;
  logic [DW-1:0] rf_wrt_data, rf_reg2;

  cpu_rf_port_ctrl_if #(.DATA_W(DW), .SEL_W(SW)) hif ();

  cpu_rf_port_ctrl #(.DATA_W(DW), .SEL_W(SW), .MAX_WAIT(8)) dut (
    .clk            (clk),
    .rst            (rst),
    .cpu_wr_en      (cpu_wr_en),
    .cpu_wr_sel     (cpu_wr_sel),
    .cpu_wr_data    (cpu_wr_data),
    .cpu_sel2       (cpu_sel2),
    .cpu_rd2_active (cpu_rd2_active),
    .cpu_stall      (cpu_stall),
    .host           (hif),
    .rf_wrt_en      (rf_wrt_en),
    .rf_wrt_sel     (rf_wrt_sel),
    .rf_wrt_data    (rf_wrt_data),
    .rf_sel2        (rf_sel2),
    .rf_reg2        (rf_reg2)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] regs [16];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) regs[i] <= '0;
      rf_reg2 <= '0;
    end else begin
      if (rf_wrt_en && rf_wrt_sel != 0) regs[rf_wrt_sel] <= rf_wrt_data;
      if (rf_sel2 == 0)                                  rf_reg2 <= '0;
      else if (rf_wrt_en && rf_wrt_sel == rf_sel2)       rf_reg2 <= rf_wrt_data;
      else                                               rf_reg2 <= regs[rf_sel2];
    end
  end

  typedef struct packed { logic [DW-1:0] data; logic err; } rsp_t;
  rsp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  logic r0_bad = 1'b0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && hif.host_rsp_valid && hif.host_rsp_ready) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_rsp: got data %h err %b expected no response",
                 hif.host_rsp_data, hif.host_rsp_err);
      end else begin
        rsp_t e;
        e = exp_q.pop_front();
        chk("rsp_data", hif.host_rsp_data, e.data);
        chk("rsp_err", {31'b0, hif.host_rsp_err}, {31'b0, e.err});
      end
    end
    if (!rst && rf_wrt_en && rf_wrt_sel == 0 && rf_wrt_data != 0) r0_bad = 1'b1;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (!hif.host_req_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!hif.host_req_ready) chk("idle_timeout", 32'd0, 32'd1);
    cyc();
  endtask

  task automatic host_issue(input logic we, input logic [SW-1:0] sel, input logic [DW-1:0] data,
                            input logic track, input rsp_t e);
    hif.host_req_valid = 1'b1;
    hif.host_req_we    = we;
    hif.host_req_sel   = sel;
    hif.host_req_data  = data;
    if (track) exp_q.push_back(e);
    cyc();
    hif.host_req_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1;
    cpu_wr_en = 0; cpu_wr_sel = 0; cpu_wr_data = 0; cpu_sel2 = 0; cpu_rd2_active = 0;
    hif.host_req_valid = 0; hif.host_req_we = 0; hif.host_req_sel = 0; hif.host_req_data = 0;
    hif.host_rsp_ready = 1;
    cyc(); cyc();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_req_ready", {31'b0, hif.host_req_ready}, 32'd1);
    chk("rst_rsp_valid", {31'b0, hif.host_rsp_valid}, 32'd0);
    chk("rst_rsp_data", hif.host_rsp_data, 32'd0);
    chk("rst_rsp_err", {31'b0, hif.host_rsp_err}, 32'd0);
    chk("rst_stall", {31'b0, cpu_stall}, 32'd0);
    cyc();

    // CPU preloads R3 through the pass-through path
    cpu_wr_en = 1; cpu_wr_sel = 3; cpu_wr_data = 32'h1234;
    @(negedge clk);
    chk("pass_wr_en", {31'b0, rf_wrt_en}, 32'd1);
    chk("pass_wr_data", rf_wrt_data, 32'h1234);
    cyc();
    cpu_wr_en = 0;

    // Host write R5
    host_issue(1'b1, 4'd5, 32'hDEADBEEF, 1'b1, '{data: 32'h0, err: 1'b0});
    @(negedge clk);
    chk("t1_wr_en", {31'b0, rf_wrt_en}, 32'd1);
    chk("t1_wr_sel", {28'b0, rf_wrt_sel}, 32'd5);
    chk("t1_wr_data", rf_wrt_data, 32'hDEADBEEF);
    wait_idle();
    cpu_sel2 = 5; cpu_rd2_active = 1;
    @(negedge clk);
    chk("t1_sel2_pass", {28'b0, rf_sel2}, 32'd5);
    cyc();
    cpu_rd2_active = 0;
    @(negedge clk);
    chk("t1_cpu_rd_r5", rf_reg2, 32'hDEADBEEF);
    cyc();

    // Host write R0 with nonzero data is rejected, later read returns zero
    host_issue(1'b1, 4'd0, 32'h1, 1'b1, '{data: 32'h0, err: 1'b1});
    @(negedge clk);
    chk("t2_no_wr_en", {31'b0, rf_wrt_en}, 32'd0);
    wait_idle();
    host_issue(1'b0, 4'd0, 32'h0, 1'b1, '{data: 32'h0, err: 1'b0});
    wait_idle();

    // Host read R3: response valid on the third cycle after accept
    host_issue(1'b0, 4'd3, 32'h0, 1'b1, '{data: 32'h1234, err: 1'b0});
    n = 1;
    @(negedge clk);
    while (!hif.host_rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("t3_latency", n, 32'd3);
    wait_idle();

    // CPU hogs the write port while a host write is pending
    cpu_wr_en = 1; cpu_wr_sel = 7; cpu_wr_data = 32'hAAAA;
    host_issue(1'b1, 4'd9, 32'h99, 1'b1, '{data: 32'h0, err: 1'b0});
`ifdef CPU_RF_STARVE_GUARD_EN
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk);
      chk("t4_stall", {31'b0, cpu_stall}, (i == 9) ? 32'd1 : 32'd0);
      chk("t4_wr_sel", {28'b0, rf_wrt_sel}, (i == 9) ? 32'd9 : 32'd7);
      if (i == 9) chk("t4_wr_data", rf_wrt_data, 32'h99);
      cyc();
    end
    @(negedge clk);
    chk("t4_stall_after", {31'b0, cpu_stall}, 32'd0);
    cyc();
    cpu_wr_en = 0;
`else
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      chk("t4_stall_off", {31'b0, cpu_stall}, 32'd0);
      chk("t4_cpu_keeps_port", {28'b0, rf_wrt_sel}, 32'd7);
      cyc();
    end
    cpu_wr_en = 0;
    @(negedge clk);
    chk("t4_host_granted", {28'b0, rf_wrt_sel}, 32'd9);
    chk("t4_host_wr_en", {31'b0, rf_wrt_en}, 32'd1);
    cyc();
`endif
    wait_idle();
    host_issue(1'b0, 4'd9, 32'h0, 1'b1, '{data: 32'h99, err: 1'b0});
    wait_idle();

    // Response back-pressure: data held stable, no new request accepted
    hif.host_rsp_ready = 0;
    host_issue(1'b0, 4'd3, 32'h0, 1'b1, '{data: 32'h1234, err: 1'b0});
    n = 0;
    @(negedge clk);
    while (!hif.host_rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    hif.host_req_valid = 1; hif.host_req_we = 0; hif.host_req_sel = 5;
    for (int i = 0; i < 5; i++) begin
      chk("t5_rsp_valid", {31'b0, hif.host_rsp_valid}, 32'd1);
      chk("t5_rsp_data", hif.host_rsp_data, 32'h1234);
      chk("t5_req_ready", {31'b0, hif.host_req_ready}, 32'd0);
      @(negedge clk);
    end
    hif.host_req_valid = 0;
    hif.host_rsp_ready = 1;
    wait_idle();

    // Reset during RD_CAP drops the request without a response
    host_issue(1'b0, 4'd5, 32'h0, 1'b0, '{data: 32'h0, err: 1'b0});
    cyc();
    rst = 1;
    cyc();
    rst = 0;
    @(negedge clk);
    chk("t6_req_ready", {31'b0, hif.host_req_ready}, 32'd1);
    chk("t6_rsp_valid", {31'b0, hif.host_rsp_valid}, 32'd0);
    for (int i = 0; i < 10; i++) cyc();

    chk("queue_drained", exp_q.size(), 32'd0);
    chk("r0_never_written", {31'b0, r0_bad}, 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
